// File: rtl/fp32_pkg.sv
// Shared types and constants for the fp32 reduction path.
package fp32_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam fp32_t FP32_ZERO = 32'h0000_0000;
  localparam fp32_t FP32_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/fp32_accumulate_pool.sv
// Operand pool for fp32_accumulate: circular buffer, up to 2 pushes and 2 pops per cycle.
// Pops always take the oldest entries; push1 is only meaningful together with push0.
module fp32_accumulate_pool
  import fp32_pkg::*;
#(
  parameter int POOL_DEPTH = 16,
  localparam int PW = $clog2(POOL_DEPTH),
  localparam int CW = $clog2(POOL_DEPTH + 1)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          push0_en,
  input  fp32_t         push0_data,
  input  logic          push1_en,
  input  fp32_t         push1_data,
  input  logic [1:0]    pop_n,
  output fp32_t         head0,
  output fp32_t         head1,
  output logic [CW-1:0] count
);

  fp32_t [POOL_DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]          rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW:0]            cnt_sum;
  logic [1:0]             push_n;

  // Pointer advance with wrap for depths that are not a power of two.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = (PW+1)'(p) + (PW+1)'(n);
    if (s >= (PW+1)'(POOL_DEPTH)) s = s - (PW+1)'(POOL_DEPTH);
    return s[PW-1:0];
  endfunction

  assign head0 = mem_q[rd_q];
  assign head1 = mem_q[ptr_add(rd_q, 2'd1)];
  assign count = count_q;

  always_comb begin
    mem_d   = mem_q;
    push_n  = {1'b0, push0_en} + {1'b0, push1_en};
    if (push0_en) mem_d[wr_q] = push0_data;
    if (push1_en) mem_d[ptr_add(wr_q, {1'b0, push0_en})] = push1_data;
    rd_d    = ptr_add(rd_q, pop_n);
    wr_d    = ptr_add(wr_q, push_n);
    cnt_sum = (CW+1)'(count_q) + (CW+1)'(push_n) - (CW+1)'(pop_n);
    count_d = cnt_sum[CW-1:0];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Underflow wraps to a large value, so one bound catches both directions.
  always_ff @(posedge clk_in) begin
    if (rst_n_in) begin
      assert (cnt_sum <= (CW+1)'(POOL_DEPTH))
        else $error("fp32_accumulate_pool: operand pool overflow");
    end
  end

endmodule

// File: rtl/fp32_accumulate.sv
// Reduces a last_in-framed stream of fp32 values to one sum through an external fp32 adder.
// Optional macro FP32_ACCUMULATE_COUNT_EN adds count_out (vector length, valid with valid_out).
module fp32_accumulate
  import fp32_pkg::*;
#(
  parameter int ADD_LATENCY = 8,
  parameter int POOL_DEPTH  = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [31:0] data_in,
  input  logic        last_in,
  output logic        add_valid_out,
  output logic [31:0] add_a_out,
  output logic [31:0] add_b_out,
  input  logic        add_valid_in,
  input  logic [31:0] add_c_in,
  output logic        valid_out,
  output logic [31:0] sum_out
`ifdef FP32_ACCUMULATE_COUNT_EN
  ,
  output logic [15:0] count_out
`endif
);

  localparam int CW = $clog2(POOL_DEPTH + 1);
  localparam int IW = $clog2(ADD_LATENCY + 2);
  localparam int FW = $clog2(ADD_LATENCY + 1);

  if (POOL_DEPTH < ADD_LATENCY + 4) begin : g_bad_depth
    $error("fp32_accumulate: POOL_DEPTH must be at least ADD_LATENCY+4");
  end

  state_e         state_q, state_d;
  logic [FW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [IW-1:0]  inflight_q, inflight_d;
  logic           add_valid_q, add_valid_d;
  fp32_t          add_a_q, add_a_d, add_b_q, add_b_d;
  logic           valid_q, valid_d;
  fp32_t          sum_q, sum_d;

  logic           in_acc, res_take, issue;
  logic           push0_en, push1_en;
  fp32_t          push0_data, push1_data, head0, head1;
  logic [1:0]     pop_n;
  logic [CW-1:0]  pool_count;

  fp32_accumulate_pool #(.POOL_DEPTH(POOL_DEPTH)) u_pool (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .push0_en   (push0_en),
    .push0_data (push0_data),
    .push1_en   (push1_en),
    .push1_data (push1_data),
    .pop_n      (pop_n),
    .head0      (head0),
    .head1      (head1),
    .count      (pool_count)
  );

  // Leaves room for one accepted element plus every result still in the adder.
  assign ready_out = (state_q == ACCUM) &&
                     (int'(pool_count) + int'(inflight_q) <= POOL_DEPTH - 2);
  assign in_acc    = valid_in && ready_out;
  // Results arriving while flushing belong to adds issued before reset.
  assign res_take  = (state_q != FLUSH) && add_valid_in;
  assign issue     = (state_q != FLUSH) && (pool_count >= CW'(2));

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    add_valid_d = 1'b0;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    valid_d     = 1'b0;
    sum_d       = sum_q;
    pop_n       = 2'd0;
    push0_en    = 1'b0;
    push0_data  = FP32_ZERO;
    push1_en    = 1'b0;
    push1_data  = FP32_ZERO;

    if (in_acc) begin
      push0_en   = 1'b1;
      push0_data = data_in;
      push1_en   = res_take;
      push1_data = add_c_in;
    end else if (res_take) begin
      push0_en   = 1'b1;
      push0_data = add_c_in;
    end

    if (issue) begin
      pop_n       = 2'd2;
      add_valid_d = 1'b1;
      add_a_d     = head0;
      add_b_d     = head1;
    end

    inflight_d = inflight_q + IW'(issue) - IW'(res_take);

    case (state_q)
      FLUSH: begin
        if (flush_cnt_q == FW'(1)) state_d = ACCUM;
        else                       flush_cnt_d = flush_cnt_q - FW'(1);
      end
      ACCUM: begin
        if (in_acc && last_in) state_d = DRAIN;
      end
      DRAIN: begin
        // Last surviving entry with nothing left in the adder is the sum.
        if (pool_count == CW'(1) && inflight_q == '0 && !add_valid_in) begin
          pop_n   = 2'd1;
          valid_d = 1'b1;
          sum_d   = head0;
          state_d = ACCUM;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= FLUSH;
      flush_cnt_q <= FW'(ADD_LATENCY);
      inflight_q  <= '0;
      add_valid_q <= 1'b0;
      add_a_q     <= FP32_ZERO;
      add_b_q     <= FP32_ZERO;
      valid_q     <= 1'b0;
      sum_q       <= FP32_ZERO;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      inflight_q  <= inflight_d;
      add_valid_q <= add_valid_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      valid_q     <= valid_d;
      sum_q       <= sum_d;
    end
  end

  assign add_valid_out = add_valid_q;
  assign add_a_out     = add_a_q;
  assign add_b_out     = add_b_q;
  assign valid_out     = valid_q;
  assign sum_out       = sum_q;

`ifdef FP32_ACCUMULATE_COUNT_EN
  logic [15:0] elem_cnt_q, elem_cnt_d, count_q, count_d;

  always_comb begin
    elem_cnt_d = elem_cnt_q;
    count_d    = count_q;
    if (valid_d) begin
      count_d    = elem_cnt_q;
      elem_cnt_d = '0;
    end else if (in_acc && elem_cnt_q != 16'hFFFF) begin
      elem_cnt_d = elem_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      elem_cnt_q <= '0;
      count_q    <= '0;
    end else begin
      elem_cnt_q <= elem_cnt_d;
      count_q    <= count_d;
    end
  end

  assign count_out = count_q;
`endif

endmodule

// File: tb/tb_fp32_accumulate.sv
// Bench for fp32_accumulate with an 8-stage behavioural fp32 adder (positive operands only).
module tb_fp32_accumulate;
  import fp32_pkg::*;

  localparam int LAT = 8;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic        valid_in, last_in, ready_out;
  logic [31:0] data_in;
  logic        add_valid_out, add_valid_in, valid_out;
  logic [31:0] add_a_out, add_b_out, add_c_in, sum_out;
`ifdef FP32_ACCUMULATE_COUNT_EN
  logic [15:0] count_out;
`endif

  fp32_accumulate #(.ADD_LATENCY(LAT), .POOL_DEPTH(16)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .data_in       (data_in),
    .last_in       (last_in),
    .add_valid_out (add_valid_out),
    .add_a_out     (add_a_out),
    .add_b_out     (add_b_out),
    .add_valid_in  (add_valid_in),
    .add_c_in      (add_c_in),
    .valid_out     (valid_out),
    .sum_out       (sum_out)
`ifdef FP32_ACCUMULATE_COUNT_EN
    ,
    .count_out     (count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Exact for positive normals whose sum is representable.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [24:0] s;
    logic [7:0]  e;
    int          d;
    if (a[30:0] == 31'd0) return b;
    if (b[30:0] == 31'd0) return a;
    if (a[30:23] >= b[30:23]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d = int'(x[30:23]) - int'(y[30:23]);
    s = {2'b01, x[22:0]} + ({2'b01, y[22:0]} >> d);
    e = x[30:23];
    if (s[24]) begin s = s >> 1; e = e + 8'd1; end
    return {1'b0, e, s[22:0]};
  endfunction

  // Adder model has no reset, like the real one.
  logic [LAT-1:0]        pv = '0;
  logic [LAT-1:0][31:0]  pd = '0;
  logic                  force_junk = 1'b0;
  always @(posedge clk_in) begin
    pv <= {pv[LAT-2:0], add_valid_out};
    pd <= {pd[LAT-2:0], fadd(add_a_out, add_b_out)};
  end
  assign add_valid_in = force_junk ? 1'b1 : pv[LAT-1];
  assign add_c_in     = force_junk ? 32'hDEAD_BEEF : pd[LAT-1];

  typedef struct {
    logic [31:0] sum;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  int cyc = 0, n_out = 0, n_issue = 0, n_rdy_low = 0, n_exp = 0;
  int out_cyc = 0, acc_cyc = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (add_valid_out) n_issue++;
      if (!ready_out) n_rdy_low++;
      if (valid_out) begin
        exp_t e;
        n_out++;
        out_cyc = cyc;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid_out: got pulse with sum_out=%h, required no pulse", sum_out);
        end else begin
          e = sb.pop_front();
          chk("sum_out", sum_out, e.sum);
`ifdef FP32_ACCUMULATE_COUNT_EN
          chk("count_out", {16'd0, count_out}, {16'd0, e.cnt});
`endif
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_elem(input logic [31:0] d, input logic last);
    int t = 0;
    valid_in = 1'b1; data_in = d; last_in = last;
    while (!ready_out) begin
      if (t == 5000) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got ready_out=0 for %0d cycles, required acceptance", t);
        valid_in = 1'b0; last_in = 1'b0;
        return;
      end
      @(negedge clk_in); t++;
    end
    @(posedge clk_in);
    @(negedge clk_in);
    acc_cyc  = cyc;
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic expect_sum(input logic [31:0] s, input int len);
    exp_t e;
    e.sum = s; e.cnt = 16'(len);
    sb.push_back(e);
    n_exp++;
  endtask

  task automatic send_vec(input int len, input logic [31:0] v, input logic [31:0] s);
    expect_sum(s, len);
    for (int i = 0; i < len; i++) send_elem(v, i == len - 1);
  endtask

  task automatic wait_outs(input string name, input int target);
    int t = 0;
    while (n_out < target && t < 3000) begin @(negedge clk_in); t++; end
    chk(name, n_out, target);
  endtask

  typedef struct {
    int          len;
    logic [31:0] val;
    logic [31:0] sum;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int base, is0, rl0, bad;
    tbl[0] = '{len: 1,  val: 32'h3F80_0000, sum: 32'h3F80_0000};
    tbl[1] = '{len: 40, val: 32'h3F00_0000, sum: 32'h41A0_0000};
    tbl[2] = '{len: 3,  val: 32'h4000_0000, sum: 32'h40C0_0000};
    tbl[3] = '{len: 7,  val: FP32_ONE,      sum: 32'h40E0_0000};
    tbl[4] = '{len: 5,  val: 32'h4080_0000, sum: 32'h41A0_0000};
    tbl[5] = '{len: 2,  val: 32'h3F00_0000, sum: 32'h3F80_0000};
    tbl[6] = '{len: 16, val: FP32_ONE,      sum: 32'h4180_0000};

    valid_in = 1'b0; data_in = '0; last_in = 1'b0;
    force_junk = 1'b1;
    #1 rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_ready_out", {31'd0, ready_out}, 32'd0);
    chk("rst_add_valid_out", {31'd0, add_valid_out}, 32'd0);
    chk("rst_add_a_out", add_a_out, 32'd0);
    chk("rst_add_b_out", add_b_out, 32'd0);
    chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("rst_sum_out", sum_out, 32'd0);

    // Flush with junk results on the adder return path.
    rst_n_in = 1'b1;
    bad = 0;
    repeat (LAT - 1) begin @(negedge clk_in); if (ready_out) bad++; end
    chk("flush_ready_low", bad, 0);
    @(negedge clk_in);
    chk("ready_after_flush", {31'd0, ready_out}, 32'd1);
    force_junk = 1'b0;
    repeat (12) @(negedge clk_in);
    chk("flush_no_issue", n_issue, 0);
    chk("flush_no_out", n_out, 0);
    chk("idle_ready", {31'd0, ready_out}, 32'd1);

    base = n_out;
    expect_sum(32'h4120_0000, 4);
    send_elem(32'h3F80_0000, 1'b0);
    send_elem(32'h4000_0000, 1'b0);
    send_elem(32'h4040_0000, 1'b0);
    send_elem(32'h4080_0000, 1'b1);
    wait_outs("vec_1234_done", base + 1);

    repeat (4) @(negedge clk_in);
    base = n_out; is0 = n_issue;
    expect_sum(32'h4049_0FDB, 1);
    send_elem(32'h4049_0FDB, 1'b1);
    wait_outs("single_done", base + 1);
    chk("single_latency", out_cyc, acc_cyc + 1);
    chk("single_no_issue", n_issue - is0, 0);

    base = n_out; rl0 = n_rdy_low;
    for (int i = 0; i < 7; i++) send_vec(tbl[i].len, tbl[i].val, tbl[i].sum);
    wait_outs("table_done", base + 7);
    chk("stream_ready_dropped", {31'd0, n_rdy_low > rl0}, 32'd1);

    // Reset mid-vector: partial sum and its in-flight adds must vanish.
    for (int i = 0; i < 5; i++) send_elem(FP32_ONE, 1'b0);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    chk("midrst_sum_out", sum_out, 32'd0);
    chk("midrst_ready_out", {31'd0, ready_out}, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    base = n_out;
    send_vec(16, FP32_ONE, 32'h4180_0000);
    wait_outs("midrst_done", base + 1);
    repeat (30) @(negedge clk_in);
    chk("midrst_one_pulse", n_out - base, 1);

    base = n_out;
    expect_sum(32'h4080_0000, 2);
    send_elem(32'h3FC0_0000, 1'b0);
    send_elem(32'h4020_0000, 1'b1);
    send_vec(1, 32'h4080_0000, 32'h4080_0000);
    wait_outs("b2b_done", base + 2);

    repeat (30) @(negedge clk_in);
    chk("total_pulses", n_out, n_exp);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required $finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
